// File: rtl/decimal_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decimal_parser_pkg: character constants, FSM states, byte classes.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package decimal_parser_pkg;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_SKIP = 2'd2,
    ST_DONE = 2'd3
  } parser_state_t;

  typedef enum logic [1:0] {
    CC_DIGIT   = 2'd0,
    CC_SEP     = 2'd1,
    CC_CR      = 2'd2,
    CC_ILLEGAL = 2'd3
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] b);
    char_class_t c;
    if (b >= CH_0 && b <= CH_9)
      c = CC_DIGIT;
    else if (b == CH_LF || b == CH_SP || b == CH_COMMA)
      c = CC_SEP;
    else if (b == CH_CR)
      c = CC_CR;
    else
      c = CC_ILLEGAL;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_accumulator: acc*10 + digit, saturating at all-ones.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module digit_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o
);

  logic [WIDTH+3:0] w_acc_ext;
  logic [WIDTH+3:0] w_wide;

  // Four extra bits hold any acc*10+9 without wrapping, so the top nibble
  // being nonzero is exactly the out-of-range condition.
  assign w_acc_ext  = {4'b0000, acc_i};
  assign w_wide     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{WIDTH{1'b0}}, digit_i};
  assign overflow_o = |w_wide[WIDTH+3:WIDTH];
  assign sum_o      = overflow_o ? {WIDTH{1'b1}} : w_wide[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/decimal_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decimal_parser: ASCII byte stream to strobed unsigned decimal values.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module decimal_parser
  import decimal_parser_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             error,
  output logic             overflow
);

  parser_state_t    state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_value_q;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
  logic             error_q;
  logic             overflow_q;

  logic             emit;
  logic [WIDTH-1:0] emit_val;
  logic             err_set;
  logic             ovf_set;
  char_class_t      w_class;
  logic [3:0]       w_digit;
  logic [WIDTH-1:0] w_sum;
  logic             w_sum_ovf;

  assign w_class = classify(in_data);
  assign w_digit = in_data[3:0];

  digit_accumulator #(.WIDTH(WIDTH)) u_acc (
    .acc_i      (acc_q),
    .digit_i    (w_digit),
    .sum_o      (w_sum),
    .overflow_o (w_sum_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    emit     = 1'b0;
    emit_val = acc_q;
    err_set  = 1'b0;
    ovf_set  = 1'b0;

    if (in_valid && state_q != ST_DONE) begin
      case (state_q)
        ST_IDLE: begin
          if (w_class == CC_DIGIT) begin
            acc_d   = {{(WIDTH-4){1'b0}}, w_digit};
            state_d = ST_NUM;
          end else if (w_class == CC_ILLEGAL) begin
            err_set = 1'b1;
            state_d = ST_SKIP;
          end
        end
        ST_NUM: begin
          if (w_class == CC_DIGIT) begin
            acc_d   = w_sum;
            ovf_set = w_sum_ovf;
          end else if (w_class == CC_SEP) begin
            emit     = 1'b1;
            emit_val = acc_q;
            acc_d    = '0;
            state_d  = ST_IDLE;
          end else if (w_class == CC_ILLEGAL) begin
            err_set = 1'b1;
            acc_d   = '0;
            state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (in_data == CH_LF)
            state_d = ST_IDLE;
        end
        default: ;
      endcase

      // The final byte is processed first; a number still open is flushed.
      if (in_last) begin
        if (state_d == ST_NUM) begin
          emit     = 1'b1;
          emit_val = acc_d;
          acc_d    = '0;
        end
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= emit;
      done_q      <= (state_d == ST_DONE);
      if (emit) begin
        out_value_q <= emit_val;
        count_q     <= count_q + WIDTH'(1);
      end
      if (err_set)
        error_q <= 1'b1;
      if (ovf_set)
        overflow_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign count     = count_q;
  assign done      = done_q;
  assign error     = error_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_decimal_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decimal_parser: directed-vector self-checking bench.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_decimal_parser;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic [WIDTH-1:0] out_value;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             error;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] got_vals[$];
  logic             got_done[$];

  decimal_parser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_value (out_value),
    .count     (count),
    .done      (done),
    .error     (error),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs change on posedge; record each strobe away from that edge.
  always @(negedge clk) begin
    if (out_valid) begin
      got_vals.push_back(out_value);
      got_done.push_back(done);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got_vals.delete();
    got_done.delete();
    reset = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = last_at_end && (i == s.len() - 1);
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        in_last  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_vals(input string tag, input int n,
                             input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                             input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3);
    logic [WIDTH-1:0] exp_v[4];
    exp_v[0] = v0; exp_v[1] = v1; exp_v[2] = v2; exp_v[3] = v3;
    check_eq({tag, ".nstrobes"}, 64'(got_vals.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s.val%0d", tag, i),
               (i < got_vals.size()) ? 64'(got_vals[i]) : 64'hDEAD_BEEF_DEAD_BEEF,
               64'(exp_v[i]));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.out_value", 64'(out_value), 64'd0);
    check_eq("rst.count",     64'(count),     64'd0);
    check_eq("rst.done",      64'(done),      64'd0);
    check_eq("rst.error",     64'(error),     64'd0);
    check_eq("rst.overflow",  64'(overflow),  64'd0);
    do_reset();

    send_str("199\n200\n208\n", 1'b1, 1'b0);
    expect_vals("t1", 3, 32'd199, 32'd200, 32'd208, 32'd0);
    check_eq("t1.count", 64'(count), 64'd3);
    check_eq("t1.done",  64'(done),  64'd1);
    check_eq("t1.error", 64'(error), 64'd0);
    send_str("5\n", 1'b1, 1'b0);
    check_eq("t1.after_done_n",     64'(got_vals.size()), 64'd3);
    check_eq("t1.after_done_count", 64'(count),           64'd3);

    do_reset();
    send_str("7\015\n\n\n12", 1'b1, 1'b0);
    expect_vals("t2", 2, 32'd7, 32'd12, 32'd0, 32'd0);
    check_eq("t2.done_at_7",  (got_done.size() > 0) ? 64'(got_done[0]) : 64'd9, 64'd0);
    check_eq("t2.done_at_12", (got_done.size() > 1) ? 64'(got_done[1]) : 64'd9, 64'd1);

    do_reset();
    send_str("4x5\n9\n", 1'b1, 1'b0);
    expect_vals("t3", 1, 32'd9, 32'd0, 32'd0, 32'd0);
    check_eq("t3.error", 64'(error), 64'd1);
    check_eq("t3.count", 64'(count), 64'd1);

    do_reset();
    send_str("4294967296\n", 1'b1, 1'b0);
    expect_vals("t4", 1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    check_eq("t4.overflow", 64'(overflow), 64'd1);

    do_reset();
    send_str("4294967295\n", 1'b1, 1'b0);
    expect_vals("t4b", 1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    check_eq("t4b.overflow", 64'(overflow), 64'd0);

    do_reset();
    send_str("123", 1'b0, 1'b0);
    do_reset();
    send_str("5\n", 1'b1, 1'b0);
    expect_vals("t5", 1, 32'd5, 32'd0, 32'd0, 32'd0);
    check_eq("t5.count", 64'(count), 64'd1);

    do_reset();
    send_str("1\n2\n3\n4\n", 1'b1, 1'b1);
    expect_vals("t6", 4, 32'd1, 32'd2, 32'd3, 32'd4);
    check_eq("t6.count", 64'(count), 64'd4);
    check_eq("t6.done",  64'(done),  64'd1);

    do_reset();
    send_str("3x", 1'b1, 1'b0);
    check_eq("t7.nstrobes", 64'(got_vals.size()), 64'd0);
    check_eq("t7.error",    64'(error),           64'd1);
    check_eq("t7.done",     64'(done),            64'd1);

    do_reset();
    send_str("8\015", 1'b1, 1'b0);
    expect_vals("t8", 1, 32'd8, 32'd0, 32'd0, 32'd0);
    check_eq("t8.done", 64'(done), 64'd1);

    do_reset();
    send_str("10,, 20,", 1'b1, 1'b0);
    expect_vals("t9", 2, 32'd10, 32'd20, 32'd0, 32'd0);
    check_eq("t9.out_value_held", 64'(out_value), 64'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
